// File: rtl/ysyx_23060077_axi_clint_slave.sv
// AXI4 single-beat CLINT slave: free-running 64-bit mtime with coherent 32-bit reads.
// Optional CLINT_MTIME_WRITE_EN makes mtime writable through the same LO/HI offsets.
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif
`ifndef AXI_STRB_WIDTH
`define AXI_STRB_WIDTH 4
`endif
`ifndef AXI_RESP_WIDTH
`define AXI_RESP_WIDTH 2
`endif

module ysyx_23060077_axi_clint_slave #(
  parameter int unsigned MTIME_DIV    = 1,
  parameter logic [15:0] MTIME_LO_OFS = 16'hbff8
) (
  input  logic                        aclk,
  input  logic                        areset_n,
  input  logic                        axi_clint_aw_valid_i,
  output logic                        axi_clint_aw_ready_o,
  input  logic [`AXI_ADDR_WIDTH-1:0]  axi_clint_aw_addr_i,
  input  logic [`AXI_ID_WIDTH-1:0]    axi_clint_aw_id_i,
  input  logic                        axi_clint_w_valid_i,
  output logic                        axi_clint_w_ready_o,
  input  logic [`AXI_DATA_WIDTH-1:0]  axi_clint_w_data_i,
  input  logic [`AXI_STRB_WIDTH-1:0]  axi_clint_w_strb_i,
  input  logic                        axi_clint_w_last_i,
  output logic                        axi_clint_b_valid_o,
  input  logic                        axi_clint_b_ready_i,
  output logic [`AXI_RESP_WIDTH-1:0]  axi_clint_b_resp_o,
  output logic [`AXI_ID_WIDTH-1:0]    axi_clint_b_id_o,
  input  logic                        axi_clint_ar_valid_i,
  output logic                        axi_clint_ar_ready_o,
  input  logic [`AXI_ADDR_WIDTH-1:0]  axi_clint_ar_addr_i,
  input  logic [`AXI_ID_WIDTH-1:0]    axi_clint_ar_id_i,
  output logic                        axi_clint_r_valid_o,
  input  logic                        axi_clint_r_ready_i,
  output logic [`AXI_DATA_WIDTH-1:0]  axi_clint_r_data_o,
  output logic [`AXI_RESP_WIDTH-1:0]  axi_clint_r_resp_o,
  output logic                        axi_clint_r_last_o,
  output logic [`AXI_ID_WIDTH-1:0]    axi_clint_r_id_o
);

  localparam int unsigned DW = `AXI_DATA_WIDTH;
  localparam int unsigned SW = `AXI_STRB_WIDTH;
  localparam int unsigned IW = `AXI_ID_WIDTH;
  localparam int unsigned RW = `AXI_RESP_WIDTH;
  localparam int unsigned PW = (MTIME_DIV > 1) ? $clog2(MTIME_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX    = PW'(MTIME_DIV - 1);
  localparam logic [15:0]   MTIME_HI_OFS = MTIME_LO_OFS + 16'd4;
  localparam logic [RW-1:0] RESP_OKAY    = 2'b00;
  localparam logic [RW-1:0] RESP_SLVERR  = 2'b10;
  localparam logic [RW-1:0] RESP_DECERR  = 2'b11;

  typedef enum logic { R_IDLE, R_DATA } r_state_t;
  typedef enum logic { W_IDLE, W_RESP } w_state_t;

  r_state_t r_state, r_state_nx;
  w_state_t w_state, w_state_nx;

  logic [63:0]   mtime, mtime_wdata;
  logic [DW-1:0] shadow;
  logic [PW-1:0] presc;
  logic          tick, mtime_wr;
  logic          rdy_en;

  // Holds every ready low while in reset and until the first clock after release.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) rdy_en <= 1'b0;
    else           rdy_en <= 1'b1;
  end

  assign tick = (presc == PRESC_MAX);

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      presc <= '0;
      mtime <= '0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (mtime_wr)  mtime <= mtime_wdata;
      else if (tick) mtime <= mtime + 64'd1;
    end
  end

  // ---------------- read channel ----------------
  logic ar_hs;
  assign axi_clint_ar_ready_o = rdy_en && (r_state == R_IDLE);
  assign ar_hs              = axi_clint_ar_valid_i && axi_clint_ar_ready_o;
  assign axi_clint_r_last_o = axi_clint_r_valid_o;

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) r_state <= R_IDLE;
    else           r_state <= r_state_nx;
  end

  always_comb begin
    r_state_nx = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_state_nx = R_DATA;
      R_DATA:  if (axi_clint_r_ready_i) r_state_nx = R_IDLE;
      default: r_state_nx = R_IDLE;
    endcase
  end

  // A LO read latches the current high word so the following HI read is coherent.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      axi_clint_r_valid_o <= 1'b0;
      axi_clint_r_data_o  <= '0;
      axi_clint_r_resp_o  <= '0;
      axi_clint_r_id_o    <= '0;
      shadow              <= '0;
    end else if (ar_hs) begin
      axi_clint_r_valid_o <= 1'b1;
      axi_clint_r_id_o    <= axi_clint_ar_id_i;
      case (axi_clint_ar_addr_i[15:0])
        MTIME_LO_OFS: begin
          axi_clint_r_data_o <= mtime[31:0];
          axi_clint_r_resp_o <= RESP_OKAY;
          shadow             <= mtime[63:32];
        end
        MTIME_HI_OFS: begin
          axi_clint_r_data_o <= shadow;
          axi_clint_r_resp_o <= RESP_OKAY;
        end
        default: begin
          axi_clint_r_data_o <= '0;
          axi_clint_r_resp_o <= RESP_DECERR;
        end
      endcase
    end else if (axi_clint_r_valid_o && axi_clint_r_ready_i) begin
      axi_clint_r_valid_o <= 1'b0;
    end
  end

  // ---------------- write channel ----------------
  logic          aw_got, w_got, aw_hs, w_hs, w_enter;
  logic [15:0]   aw_ofs_q, wr_ofs;
  logic [IW-1:0] aw_id_q, wr_id;
  logic          wr_lo, wr_hi;

  assign axi_clint_aw_ready_o = rdy_en && (w_state == W_IDLE) && !aw_got;
  assign axi_clint_w_ready_o  = rdy_en && (w_state == W_IDLE) && !w_got;
  assign aw_hs   = axi_clint_aw_valid_i && axi_clint_aw_ready_o;
  assign w_hs    = axi_clint_w_valid_i && axi_clint_w_ready_o;
  assign w_enter = (w_state == W_IDLE) && (aw_got || aw_hs) && (w_got || w_hs);
  assign wr_ofs  = aw_hs ? axi_clint_aw_addr_i[15:0] : aw_ofs_q;
  assign wr_id   = aw_hs ? axi_clint_aw_id_i : aw_id_q;
  assign wr_lo   = (wr_ofs == MTIME_LO_OFS);
  assign wr_hi   = (wr_ofs == MTIME_HI_OFS);

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) w_state <= W_IDLE;
    else           w_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = w_state;
    case (w_state)
      W_IDLE:  if (w_enter) w_state_nx = W_RESP;
      W_RESP:  if (axi_clint_b_ready_i) w_state_nx = W_IDLE;
      default: w_state_nx = W_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      aw_got   <= 1'b0;
      w_got    <= 1'b0;
      aw_ofs_q <= '0;
      aw_id_q  <= '0;
    end else begin
      if (aw_hs) begin
        aw_ofs_q <= axi_clint_aw_addr_i[15:0];
        aw_id_q  <= axi_clint_aw_id_i;
      end
      aw_got <= w_enter ? 1'b0 : (aw_got || aw_hs);
      w_got  <= w_enter ? 1'b0 : (w_got || w_hs);
    end
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      axi_clint_b_valid_o <= 1'b0;
      axi_clint_b_resp_o  <= '0;
      axi_clint_b_id_o    <= '0;
    end else if (w_enter) begin
      axi_clint_b_valid_o <= 1'b1;
      axi_clint_b_id_o    <= wr_id;
`ifdef CLINT_MTIME_WRITE_EN
      axi_clint_b_resp_o  <= (wr_lo || wr_hi) ? RESP_OKAY : RESP_DECERR;
`else
      axi_clint_b_resp_o  <= (wr_lo || wr_hi) ? RESP_SLVERR : RESP_DECERR;
`endif
    end else if (axi_clint_b_valid_o && axi_clint_b_ready_i) begin
      axi_clint_b_valid_o <= 1'b0;
    end
  end

`ifdef CLINT_MTIME_WRITE_EN
  logic [DW-1:0] w_data_q, wr_data, wword;
  logic [SW-1:0] w_strb_q, wr_strb;

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      w_data_q <= '0;
      w_strb_q <= '0;
    end else if (w_hs) begin
      w_data_q <= axi_clint_w_data_i;
      w_strb_q <= axi_clint_w_strb_i;
    end
  end

  assign wr_data = w_hs ? axi_clint_w_data_i : w_data_q;
  assign wr_strb = w_hs ? axi_clint_w_strb_i : w_strb_q;

  // The write lands on the same edge that completes the address/data pair.
  always_comb begin
    mtime_wr    = 1'b0;
    mtime_wdata = mtime;
    wword       = wr_hi ? mtime[63:32] : mtime[31:0];
    for (int unsigned i = 0; i < SW; i++) begin
      if (wr_strb[i]) wword[8*i +: 8] = wr_data[8*i +: 8];
    end
    if (w_enter && wr_lo) begin
      mtime_wr          = 1'b1;
      mtime_wdata[31:0] = wword;
    end else if (w_enter && wr_hi) begin
      mtime_wr           = 1'b1;
      mtime_wdata[63:32] = wword;
    end
  end

  logic unused_ok;
  assign unused_ok = ^{axi_clint_w_last_i, axi_clint_aw_addr_i[`AXI_ADDR_WIDTH-1:16],
                       axi_clint_ar_addr_i[`AXI_ADDR_WIDTH-1:16]};
`else
  assign mtime_wr    = 1'b0;
  assign mtime_wdata = mtime;

  logic unused_ok;
  assign unused_ok = ^{axi_clint_w_last_i, axi_clint_w_data_i, axi_clint_w_strb_i,
                       axi_clint_aw_addr_i[`AXI_ADDR_WIDTH-1:16],
                       axi_clint_ar_addr_i[`AXI_ADDR_WIDTH-1:16]};
`endif

endmodule
